micro_sequencer: RTL

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 79 +++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// Microprogrammed sequencer: control store plus two opcode dispatch tables, all loadable at run time.
// Optional MICROSEQ_STALL_EN adds a stall input that freezes the micro-state and suppresses instr_done.
module micro_sequencer #(
  parameter int UW = 17,
  parameter int SW = 4,
  parameter int OW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [OW-1:0] opcode,
`ifdef MICROSEQ_STALL_EN
  input  logic          stall,
`endif
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [OW-1:0] wr_addr,
  input  logic [UW-1:0] wr_data,
  output logic [SW-1:0] state,
  output logic [UW-1:0] microinstruction,
  output logic          instr_done
);

  localparam int CS_DEPTH = 2 ** SW;
  localparam int DT_DEPTH = 2 ** OW;

  logic [UW-1:0] r_cstore [CS_DEPTH];
  logic [SW-1:0] r_dt1    [DT_DEPTH];
  logic [SW-1:0] r_dt2    [DT_DEPTH];
  logic [SW-1:0] r_state;
  logic          r_done;
  logic [SW-1:0] w_next;
  logic          w_hold;

`ifdef MICROSEQ_STALL_EN
  assign w_hold = stall;
`else
  assign w_hold = 1'b0;
`endif

  assign state            = r_state;
  assign instr_done       = r_done;
  assign microinstruction = r_cstore[r_state];

  // The low two bits of the current word choose where the sequence goes next.
  always_comb begin
    w_next = '0;
    case (microinstruction[1:0])
      2'b00:   w_next = '0;
      2'b01:   w_next = r_dt1[opcode];
      2'b10:   w_next = r_dt2[opcode];
      default: w_next = r_state + {{(SW-1){1'b0}}, 1'b1};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
      r_done  <= 1'b0;
    end else if (w_hold) begin
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == '0);
    end
  end

  // Arrays are never reset and load independently of stall; reads above see pre-edge contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (wr_sel)
        2'b00:   r_cstore[wr_addr[SW-1:0]] <= wr_data;
        2'b01:   r_dt1[wr_addr]            <= wr_data[SW-1:0];
        2'b10:   r_dt2[wr_addr]            <= wr_data[SW-1:0];
        default: ;
      endcase
    end
  end

endmodule
